store_unit: RTL and testbench
=============================

# store_unit

Store-side counterpart of the load writeback path in the 5-stage RV32I pipeline. Accepts SB/SH/SW requests from EX, aligns `rs2` data onto the byte lanes of a 32-bit data memory, and generates byte write enables. Drives a req/ack write port to data SRAM and stalls EX while a write is outstanding. Misaligned or illegal stores are flagged and never reach memory.

## Interface
- `ADDR_W`, 32: byte address width.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `st_valid_fromEX` input 1: store request valid.
- `st_ready_toEX` output 1: request accepted on the edge where valid && ready.
- `funct3_fromEX` input 3: `SB`=000, `SH`=001, `SW`=010; others are illegal.
- `addr_fromEX` input ADDR_W: byte address.
- `rs2_data_fromEX` input 32: store data, right-justified.
- `dm_req` output 1: write request to data memory.
- `dm_ack` input 1: memory has accepted the write this cycle.
- `dm_addr` output ADDR_W: word address, bits [1:0] always 0.
- `dm_wen` output 4: active-high byte write enable, bit i = byte lane i.
- `dm_wdata` output 32: lane-aligned write data.
- `misalign_err` output 1: one-cycle pulse for a bad store.
- `err_addr` output ADDR_W: address of the last bad store, held until the next one.
- `st_count` output 32: completed memory writes, wraps at 2^32.

## Operation
- **States:** IDLE, REQ.
- **Ready:** `st_ready_toEX` = (state==IDLE) | (state==REQ & dm_ack). Combinational; back-to-back stores are supported.
- **Accepted legal store:** registers `dm_addr`={addr[ADDR_W-1:2],2'b00}, `dm_wen`, and `dm_wdata`. State becomes REQ. `dm_req`=1.
- **Lane rules, `off`=addr[1:0]:**
  - SB: wen=4'b0001<<off; wdata = rs2[7:0] replicated to all 4 lanes.
  - SH: wen=4'b0011<<off (off is 0 or 2); wdata = rs2[15:0] replicated twice.
  - SW: wen=4'b1111; wdata=rs2.
- **Accepted bad store:** SH with off[0]=1, SW with off≠0, or any illegal funct3.
  - `misalign_err`=1 for the next cycle and `err_addr`=addr.
  - No memory request is issued.
  - Next state is IDLE, unless this acceptance coincided with an ack, in which case the next state is still IDLE.
- **REQ:** `dm_req`, `dm_addr`, `dm_wen`, and `dm_wdata` are held stable until `dm_ack` is sampled high.
  - On ack: `st_count`+=1.
  - If a legal store is accepted the same cycle, the outputs load the new store and the state stays REQ.
  - Otherwise the next state is IDLE and `dm_req`=0.
- `dm_wen` and `dm_wdata` are 0 whenever `dm_req`=0.
- `dm_ack` while IDLE is ignored.

## Timing
- **Reset values (next edge with `rst`=1):** state IDLE; `dm_req`=0, `dm_addr`=0, `dm_wen`=0, `dm_wdata`=0, `misalign_err`=0, `err_addr`=0, `st_count`=0.
- **Reset mid-REQ:** the pending write is dropped and not counted. Memory must tolerate `dm_req` deasserting without ack.
- **Latency:** store accepted at edge N gives `dm_req`=1 in cycle N+1. With ack in cycle N+1, the write completes at edge N+2. Sustained throughput is 1 store/cycle when `dm_ack` is tied high.
- `misalign_err` is asserted in cycle N+1 for exactly one cycle per bad store.
- Ack and bad-store acceptance in the same cycle: the ack is counted, `dm_req` drops, and the error pulses.
- `st_count` increments only on an ack edge with state==REQ.

## Structure
- **Shared pipeline package:** funct3 store codes `SB`/`SH`/`SW` (beside the `LB`..`LHU` load codes) and the state enum `st_state_e`.
- **Sub-module `store_align` (combinational):** funct3, off, rs2 → wen, wdata, bad. It is reused by the load path for lane checks. The FSM, registers, and counter live in `store_unit`.

## Test plan
- **Reset:** hold `rst` 2 cycles while in REQ → all outputs 0 and `st_count`=0. Then SW addr 0x100, rs2 0xDEADBEEF, ack next cycle → `dm_addr`=0x100, wen=1111, wdata=0xDEADBEEF, `st_count`=1.
- **SB lanes:** SB addr 0x203, rs2 0x000000A5 → `dm_addr`=0x200, wen=1000, wdata=0xA5A5A5A5. SH addr 0x202, rs2 0x1234 → wen=1100, wdata=0x12341234.
- **Stall:** SW with `dm_ack`=0 for 5 cycles → `st_ready_toEX`=0 and the outputs stay stable throughout. On the ack cycle ready=1 and a queued SB is accepted → `dm_req` stays high with the new wen.
- **Bad stores:** SW addr 0x102 → `misalign_err` pulses one cycle, `err_addr`=0x102, `dm_req` never asserts, `st_count` unchanged. Repeat with funct3=011.
- **Throughput:** `dm_ack` tied 1, 8 consecutive legal stores → `dm_req` high 8 consecutive cycles and `st_count`=8.
- **Counter wrap:** preload `st_count`=0xFFFFFFFF (force), one write → `st_count`=0.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared pipeline definitions for the memory stage: load/store funct3 codes
// and the store unit state encoding.
package store_unit_pkg;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } st_state_e;

endpackage

// File: rtl/store_unit_align.sv
// Combinational byte-lane steering for stores: write enables, replicated data
// and a flag for misaligned or unsupported accesses.
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  output logic [3:0]  wen,
  output logic [31:0] wdata,
  output logic        bad
);

  logic [31:0] byte_rep;
  logic [31:0] half_rep;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_rep[gi*8 +: 8] = rs2[7:0];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_rep[gi*16 +: 16] = rs2[15:0];
    end
  endgenerate

  // A bad access drives no lanes so callers can OR results freely.
  always_comb begin
    wen   = 4'b0000;
    wdata = 32'h0;
    bad   = 1'b1;
    case (funct3)
      SB: begin
        wen   = 4'b0001 << off;
        wdata = byte_rep;
        bad   = 1'b0;
      end
      SH: begin
        if (!off[0]) begin
          wen   = 4'b0011 << off;
          wdata = half_rep;
          bad   = 1'b0;
        end
      end
      SW: begin
        if (off == 2'b00) begin
          wen   = 4'b1111;
          wdata = rs2;
          bad   = 1'b0;
        end
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store path: accepts SB/SH/SW from EX, drives a req/ack write port to data
// memory, reports bad stores and counts completed writes.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_fromEX,
  output logic              st_ready_toEX,
  input  logic [2:0]        funct3_fromEX,
  input  logic [ADDR_W-1:0] addr_fromEX,
  input  logic [31:0]       rs2_data_fromEX,
  output logic              dm_req,
  input  logic              dm_ack,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wen,
  output logic [31:0]       dm_wdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [31:0]       st_count
);

  st_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] dm_addr_reg;
  logic [3:0]        dm_wen_reg;
  logic [31:0]       dm_wdata_reg;
  logic              misalign_err_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic [31:0]       st_count_reg, st_count_next;

  logic [3:0]  al_wen;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic        accept;
  logic        ack_done;
  logic        load_new;

  store_align u_align (
    .funct3 (funct3_fromEX),
    .off    (addr_fromEX[1:0]),
    .rs2    (rs2_data_fromEX),
    .wen    (al_wen),
    .wdata  (al_wdata),
    .bad    (al_bad)
  );

  assign ack_done      = (state_reg == REQ) && dm_ack;
  assign st_ready_toEX = (state_reg == IDLE) || ack_done;
  assign accept        = st_valid_fromEX && st_ready_toEX;
  assign load_new      = accept && !al_bad;
  assign st_count_next = st_count_reg + {31'd0, ack_done};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (load_new) state_next = REQ;
      REQ:  if (dm_ack)   state_next = load_new ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      dm_addr_reg      <= '0;
      dm_wen_reg       <= 4'b0000;
      dm_wdata_reg     <= 32'h0;
      misalign_err_reg <= 1'b0;
      err_addr_reg     <= '0;
      st_count_reg     <= 32'h0;
    end else begin
      state_reg        <= state_next;
      st_count_reg     <= st_count_next;
      misalign_err_reg <= accept && al_bad;
      if (accept && al_bad) err_addr_reg <= addr_fromEX;
      if (load_new) begin
        dm_addr_reg  <= {addr_fromEX[ADDR_W-1:2], 2'b00};
        dm_wen_reg   <= al_wen;
        dm_wdata_reg <= al_wdata;
      end else if (state_next == IDLE) begin
        // Lanes and data read as zero whenever no request is outstanding.
        dm_wen_reg   <= 4'b0000;
        dm_wdata_reg <= 32'h0;
      end
    end
  end

  assign dm_req       = (state_reg == REQ);
  assign dm_addr      = dm_addr_reg;
  assign dm_wen       = dm_wen_reg;
  assign dm_wdata     = dm_wdata_reg;
  assign misalign_err = misalign_err_reg;
  assign err_addr     = err_addr_reg;
  assign st_count     = st_count_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a per-cycle behavioural reference model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic        dm_req;
  logic        dm_ack;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic [31:0] st_count;

  int total = 0;
  int bad   = 0;

  store_unit #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .st_valid_fromEX (st_valid),
    .st_ready_toEX   (st_ready),
    .funct3_fromEX   (f3),
    .addr_fromEX     (addr),
    .rs2_data_fromEX (rs2),
    .dm_req          (dm_req),
    .dm_ack          (dm_ack),
    .dm_addr         (dm_addr),
    .dm_wen          (dm_wen),
    .dm_wdata        (dm_wdata),
    .misalign_err    (misalign_err),
    .err_addr        (err_addr),
    .st_count        (st_count)
  );

  always #5 clk = ~clk;

  // Reference model: what the write port must show, from the store rules.
  logic        m_req = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [3:0]  m_wen = 4'h0;
  logic [31:0] m_wdata = 32'h0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = 32'h0;
  logic [31:0] m_count = 32'h0;

  always @(posedge clk) begin
    logic       acc, legal, done;
    logic [7:0] mask8;
    if (rst) begin
      m_req = 0; m_addr = 0; m_wen = 0; m_wdata = 0;
      m_err = 0; m_err_addr = 0; m_count = 0;
    end else begin
      done  = m_req && dm_ack;
      acc   = st_valid && (!m_req || dm_ack);
      legal = (f3 <= 3'd2) && ((addr % (32'd1 << f3)) == 0);
      if (done) m_count = m_count + 1;
      m_err = acc && !legal;
      if (acc && !legal) m_err_addr = addr;
      if (acc && legal) begin
        m_req   = 1'b1;
        m_addr  = addr & ~32'd3;
        mask8   = (8'd1 << (8'd1 << f3)) - 8'd1;
        m_wen   = 4'(mask8 << addr[1:0]);
        m_wdata = (f3 == 3'd0) ? {24'd0, rs2[7:0]} * 32'h01010101 :
                  (f3 == 3'd1) ? {16'd0, rs2[15:0]} * 32'h00010001 : rs2;
      end else if (done) begin
        m_req = 1'b0; m_wen = 0; m_wdata = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("ready", {31'd0, st_ready}, {31'd0, (!m_req || dm_ack)});
      chk("req", {31'd0, dm_req}, {31'd0, m_req});
      if (m_req) chk("addr", dm_addr, m_addr);
      chk("wen", {28'd0, dm_wen}, {28'd0, m_wen});
      chk("wdata", dm_wdata, m_wdata);
      chk("err", {31'd0, misalign_err}, {31'd0, m_err});
      chk("err_addr", err_addr, m_err_addr);
      chk("count", st_count, m_count);
    end
  end

  task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic k);
    @(negedge clk);
    st_valid = v; f3 = f; addr = a; rs2 = d; dm_ack = k;
    $display("cyc t=%0t valid=%0d f3=%0d addr=%h rs2=%h ack=%0d", $time, v, f, a, d, k);
  endtask

  task automatic idle(input logic k);
    step(1'b0, 3'd0, 32'h0, 32'h0, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_hi;
    logic [31:0] c0;
    rst = 1; st_valid = 0; f3 = 0; addr = 0; rs2 = 0; dm_ack = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // Enter REQ, then reset for two cycles: pending write is dropped.
    step(1, 3'd2, 32'h40, 32'h11, 0);
    idle(0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    @(negedge clk); rst = 0; #3;
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_wen", {28'd0, dm_wen}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_count", st_count, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);

    // SW 0x100, ack the cycle after acceptance.
    step(1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    idle(1); #3;
    chk("sw_addr", dm_addr, 32'h100);
    chk("sw_wen", {28'd0, dm_wen}, 32'hF);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    idle(0); #3;
    chk("sw_count", st_count, 32'd1);

    // Byte and halfword lanes.
    step(1, 3'd0, 32'h203, 32'h000000A5, 0);
    idle(1); #3;
    chk("sb_addr", dm_addr, 32'h200);
    chk("sb_wen", {28'd0, dm_wen}, 32'h8);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    step(1, 3'd1, 32'h202, 32'h00001234, 0);
    idle(1); #3;
    chk("sh_wen", {28'd0, dm_wen}, 32'hC);
    chk("sh_wdata", dm_wdata, 32'h12341234);
    idle(0);

    // Stall for five cycles, then ack with a queued SB.
    step(1, 3'd2, 32'h300, 32'hCAFEF00D, 0);
    for (int i = 0; i < 5; i++) begin
      idle(0); #3;
      chk("stall_ready", {31'd0, st_ready}, 32'd0);
      chk("stall_wdata", dm_wdata, 32'hCAFEF00D);
    end
    step(1, 3'd0, 32'h301, 32'h77, 1); #3;
    chk("stall_ack_ready", {31'd0, st_ready}, 32'd1);
    idle(1); #3;
    chk("chain_req", {31'd0, dm_req}, 32'd1);
    chk("chain_wen", {28'd0, dm_wen}, 32'h2);
    chk("chain_wdata", dm_wdata, 32'h77777777);
    idle(0); #3;
    chk("chain_count", st_count, 32'd5);

    // Bad stores: misaligned SW and illegal funct3.
    step(1, 3'd2, 32'h102, 32'h1, 0);
    idle(0); #3;
    chk("bad_err", {31'd0, misalign_err}, 32'd1);
    chk("bad_err_addr", err_addr, 32'h102);
    chk("bad_req", {31'd0, dm_req}, 32'd0);
    idle(0); #3;
    chk("bad_pulse_end", {31'd0, misalign_err}, 32'd0);
    chk("bad_count", st_count, 32'd5);
    step(1, 3'd3, 32'h104, 32'h2, 0);
    idle(0); #3;
    chk("f3_err", {31'd0, misalign_err}, 32'd1);
    chk("f3_err_addr", err_addr, 32'h104);

    // Bad store accepted on the ack cycle of a pending write.
    step(1, 3'd2, 32'h108, 32'h3, 0);
    step(1, 3'd1, 32'h10B, 32'h4, 1);
    idle(0); #3;
    chk("ackbad_req", {31'd0, dm_req}, 32'd0);
    chk("ackbad_err", {31'd0, misalign_err}, 32'd1);
    chk("ackbad_count", st_count, 32'd6);

    // Throughput with ack tied high.
    c0 = st_count;
    req_hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i % 3), 32'h400 + 32'(4 * i), 32'(i + 1), 1); #3;
      if (i > 0 && dm_req) req_hi++;
    end
    idle(1); #3;
    if (dm_req) req_hi++;
    idle(0); #3;
    chk("tput_req_cycles", 32'(req_hi), 32'd8);
    chk("tput_count", st_count, c0 + 32'd8);

    // Counter wrap.
    @(negedge clk);
    force dut.st_count_reg = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    idle(0);
    #1 release dut.st_count_reg;
    step(1, 3'd2, 32'h500, 32'h5, 0);
    idle(1);
    idle(0); #3;
    chk("wrap_count", st_count, 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
